// File: rtl/mod_accum_pkg.sv
// Shared widths, FSM state type and the signed clamp helper
// for the accumulate-and-emit stage.
package mod_accum_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int COUNT_W_DEF = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // Returns {clamped_flag, value clamped to a dw-bit signed range}
  function automatic logic [64:0] sat_to_width(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return {1'b1, hi};
    if (v < lo) return {1'b1, lo};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/mod_accum_stage_sat.sv
// Combinational clamp of the wide accumulator to DATA_W,
// followed by an optional ReLU that leaves the clamp flag alone.
module mod_sat_relu
  import mod_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic              doRelu,
  output logic [DATA_W-1:0] result,
  output logic              saturated
);

  logic [63:0]       w_ext;
  logic [64:0]       w_sat;
  logic [DATA_W-1:0] w_clamp;
  logic              w_unused;

  assign w_ext     = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
  assign w_sat     = sat_to_width(w_ext, DATA_W);
  assign w_clamp   = w_sat[DATA_W-1:0];
  assign saturated = w_sat[64];
  assign w_unused  = ^w_sat[63:DATA_W];

  assign result = (doRelu && w_clamp[DATA_W-1]) ? '0 : w_clamp;

endmodule

// File: rtl/mod_accum_stage.sv
// Groups N signed samples onto a biased accumulator and emits one
// clamped (optionally ReLU'd) result per group, or early on flush.
module mod_accum_stage
  import mod_accum_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] newNumAdds,
  input  logic               loadCfg,
  input  logic [DATA_W-1:0]  bias,
  input  logic               doRelu,
  input  logic               inReady,
  input  logic [DATA_W-1:0]  inValue,
  input  logic               flush,
  output logic               outReady,
  output logic [DATA_W-1:0]  result,
  output logic               saturated,
  output logic               busy
);

  state_t             r_state;
  state_t             w_next;
  logic [COUNT_W-1:0] r_n;
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] w_nEff;
  logic [COUNT_W-1:0] w_cntCur;
  logic [DATA_W-1:0]  r_bias;
  logic               r_relu;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_add;
  logic [ACC_W-1:0]   w_sum;
  logic               w_idle;
  logic               w_last;
  logic               w_emit;
  logic [DATA_W-1:0]  w_result;
  logic               w_sat;
  logic               r_outReady;
  logic [DATA_W-1:0]  r_result;
  logic               r_sat;

  assign w_idle   = (r_state == S_IDLE);
  assign w_nEff   = (r_n == '0) ? COUNT_W'(1) : r_n;
  assign w_cntCur = w_idle ? '0 : r_cnt;

  // A new group always starts from bias, never from a stale acc
  assign w_base = w_idle
    ? {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias}
    : r_acc;
  assign w_add = inReady
    ? {{(ACC_W-DATA_W){inValue[DATA_W-1]}}, inValue}
    : '0;
  assign w_sum = w_base + w_add;

  assign w_last = inReady && (w_cntCur == w_nEff - COUNT_W'(1));
  assign w_emit = w_last || (flush && (!w_idle || inReady));

  mod_sat_relu #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat (
    .acc       (w_sum),
    .doRelu    (r_relu),
    .result    (w_result),
    .saturated (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_emit)       w_next = S_IDLE;
    else if (inReady) w_next = S_ACCUM;
  end

  always_comb begin
    busy = (r_state == S_ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= COUNT_W'(1);
      r_bias     <= '0;
      r_relu     <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_outReady <= 1'b0;
      r_result   <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (loadCfg && w_idle) begin
        r_n    <= newNumAdds;
        r_bias <= bias;
        r_relu <= doRelu;
      end
      if (w_emit) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (inReady) begin
        r_acc <= w_sum;
        r_cnt <= w_cntCur + COUNT_W'(1);
      end
      r_outReady <= w_emit;
      if (w_emit) begin
        r_result <= w_result;
        r_sat    <= w_sat;
      end
    end
  end

  assign outReady  = r_outReady;
  assign result    = r_result;
  assign saturated = r_sat;

endmodule

// File: tb/tb_mod_accum_stage.sv
// Directed scenarios for mod_accum_stage with hand-computed
// Q5.10 expectations.
module tb_mod_accum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] newNumAdds;
  logic        loadCfg;
  logic [15:0] bias;
  logic        doRelu;
  logic        inReady;
  logic [15:0] inValue;
  logic        flush;
  logic        outReady;
  logic [15:0] result;
  logic        saturated;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_accum_stage #(
    .DATA_W  (16),
    .ACC_W   (24),
    .COUNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .newNumAdds (newNumAdds),
    .loadCfg    (loadCfg),
    .bias       (bias),
    .doRelu     (doRelu),
    .inReady    (inReady),
    .inValue    (inValue),
    .flush      (flush),
    .outReady   (outReady),
    .result     (result),
    .saturated  (saturated),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] n, input logic [15:0] b,
                     input logic r);
    loadCfg = 1'b1; newNumAdds = n; bias = b; doRelu = r;
    tick();
    loadCfg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; loadCfg = 0; newNumAdds = 0; bias = 0;
    doRelu = 0; inReady = 0; inValue = 0; flush = 0;
    tick(); tick();
    n_cmp++;
    if ({outReady, result, saturated, busy} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 0",
               {outReady, result, saturated, busy});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int strobes = 0;
    cfg(16'd3, 16'h0000, 1'b0);
    inReady = 1'b1; inValue = 16'h0400;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_cmp++;
      if (outReady !== ((i % 3) == 0)) begin
        n_bad++;
        $display("FAIL basic_strobe cyc%0d got %b want %b",
                 i, outReady, (i % 3) == 0);
      end
      if (outReady === 1'b1) begin
        strobes++;
        n_cmp++;
        if (result !== 16'h0C00 || saturated !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_result got %h/%b want 0c00/0",
                   result, saturated);
        end
      end
    end
    inReady = 1'b0;
    tick();
    n_cmp++;
    if (strobes != 3) begin
      n_bad++;
      $display("FAIL basic_count got %0d want 3", strobes);
    end
    n_cmp++;
    if (outReady !== 1'b0 || result !== 16'h0C00) begin
      n_bad++;
      $display("FAIL basic_hold got %b/%h want 0/0c00",
               outReady, result);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] vals [2] = '{16'h7000, 16'h9000};
    logic [15:0] exps [2] = '{16'h7FFF, 16'h8000};
    cfg(16'd4, 16'h0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      inReady = 1'b1; inValue = vals[k];
      repeat (4) tick();
      inReady = 1'b0;
      n_cmp++;
      if (outReady !== 1'b1 || result !== exps[k] ||
          saturated !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_%0d got %b/%h/%b want 1/%h/1",
                 k, outReady, result, saturated, exps[k]);
      end
      tick();
    end
  endtask

  task automatic test_relu_bias();
    logic [15:0] exps [2] = '{16'h0000, 16'hFA00};
    for (int k = 0; k < 2; k++) begin
      cfg(16'd2, 16'h0200, (k == 0));
      inReady = 1'b1; inValue = 16'hFC00;
      repeat (2) tick();
      inReady = 1'b0;
      n_cmp++;
      if (outReady !== 1'b1 || result !== exps[k] ||
          saturated !== 1'b0) begin
        n_bad++;
        $display("FAIL relu_%0d got %b/%h/%b want 1/%h/0",
                 k, outReady, result, saturated, exps[k]);
      end
      tick();
    end
  endtask

  task automatic test_passthru();
    cfg(16'd0, 16'h0100, 1'b0);
    inReady = 1'b1; inValue = 16'h0200;
    tick();
    inReady = 1'b0;
    n_cmp++;
    if (outReady !== 1'b1 || result !== 16'h0300 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL n0_pass got %b/%h/%b want 1/0300/0",
               outReady, result, busy);
    end
    tick();
  endtask

  task automatic test_flush();
    cfg(16'd5, 16'h0000, 1'b0);
    inReady = 1'b1; inValue = 16'h0400;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b1 || outReady !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_busy got %b/%b want 1/0", busy, outReady);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; inReady = 1'b0;
    n_cmp++;
    if (outReady !== 1'b1 || result !== 16'h0C00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_emit got %b/%h/%b want 1/0c00/0",
               outReady, result, busy);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (outReady !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle got %b/%b want 0/0", outReady, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    cfg(16'd3, 16'h0000, 1'b0);
    inReady = 1'b1; inValue = 16'h0400;
    repeat (2) tick();
    inReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({outReady, result, saturated, busy} !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_mid got %h want 0",
               {outReady, result, saturated, busy});
    end
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      if (outReady === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_nostrobe got %0d want 0", seen);
    end
    inReady = 1'b1; inValue = 16'h0100;
    tick();
    inReady = 1'b0;
    n_cmp++;
    if (outReady !== 1'b1 || result !== 16'h0100) begin
      n_bad++;
      $display("FAIL rst_n1 got %b/%h want 1/0100", outReady, result);
    end
    tick();
  endtask

  task automatic test_cfg_ignored();
    cfg(16'd3, 16'h0000, 1'b0);
    inReady = 1'b1; inValue = 16'h0400;
    tick();
    loadCfg = 1'b1; newNumAdds = 16'd7; bias = 16'h1000;
    tick();
    loadCfg = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || outReady !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_mid got %b/%b want 1/0", busy, outReady);
    end
    tick();
    inReady = 1'b0;
    n_cmp++;
    if (outReady !== 1'b1 || result !== 16'h0C00) begin
      n_bad++;
      $display("FAIL cfg_ignored got %b/%h want 1/0c00",
               outReady, result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu_bias();
    test_passthru();
    test_flush();
    test_reset_mid();
    test_cfg_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
